// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Groups the game-flow control signals exchanged between the sequencer and
//   the rest of the brick-breaker design (keyboard decoder, VGA timing,
//   ball/board/brick datapath).
//
//   Signals:
//     vsync        - VGA vsync, active-low pulse, asynchronous to clk
//     start_key    - one-cycle pulse, start/pause key pressed
//     ball_lost    - level, ball is below the paddle line
//     bricks_empty - level, brick map holds no nonzero cell
//     step_en      - one-cycle pulse, datapath registers advance
//     load_level   - one-cycle pulse, load level map / reset positions
//     serve        - one-cycle pulse, initialise ball velocity/direction
//     lives        - remaining lives
//     state        - current sequencer state encoding
//     game_over    - high while the game is lost
//     win          - high while the level is cleared
//
//   Modports:
//     master - the sequencer (drives the control outputs)
//     slave  - the surrounding design (drives the status inputs)

interface game_sequencer_if;
  logic       vsync;
  logic       start_key;
  logic       ball_lost;
  logic       bricks_empty;
  logic       step_en;
  logic       load_level;
  logic       serve;
  logic [1:0] lives;
  logic [2:0] state;
  logic       game_over;
  logic       win;

  modport master (
    input  vsync,
    input  start_key,
    input  ball_lost,
    input  bricks_empty,
    output step_en,
    output load_level,
    output serve,
    output lives,
    output state,
    output game_over,
    output win
  );

  modport slave (
    output vsync,
    output start_key,
    output ball_lost,
    output bricks_empty,
    input  step_en,
    input  load_level,
    input  serve,
    input  lives,
    input  state,
    input  game_over,
    input  win
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//   Game-flow controller for the brick-breaker design. Decides when a level
//   is loaded, when the ball is served and on which cycles the ball-control
//   registers may advance (frame-paced step_en). Tracks lives and detects
//   win / lose.
//
//   Parameters:
//     LIVES        - lives granted at level load (1..3)
//     SERVE_FRAMES - frame ticks spent in SERVE before launch (1..255)
//     STEP_DIV     - frame ticks per physics step in PLAY (1..15)
//
//   Ports:
//     clk - system clock, rising edge
//     rst - asynchronous reset, active low
//     bus - game_sequencer_if.master (see interface file for signal list)
//
//   Build option:
//     GAME_PAUSE_EN - when defined, start_key in PLAY enters PAUSE and
//                     start_key in PAUSE resumes PLAY. When undefined,
//                     PAUSE is unreachable and start_key is ignored in PLAY.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | 0: waiting for start_key after reset
//   LOAD  | 1: single cycle, level map loaded, lives refilled
//   SERVE | 2: counting frame ticks before the ball launches
//   PLAY  | 3: ball in motion, step_en paced by frame ticks
//   LOST  | 4: single cycle, one life consumed
//   OVER  | 5: no lives left, waiting for start_key
//   WIN   | 6: brick map cleared, waiting for start_key
//   PAUSE | 7: counters frozen (GAME_PAUSE_EN builds only)

module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int STEP_DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  game_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SERVE = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_LOST  = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;
  localparam logic [2:0] ST_WIN   = 3'd6;
  localparam logic [2:0] ST_PAUSE = 3'd7;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES);
  localparam logic [3:0] STEP_LAST  = 4'(STEP_DIV - 1);

  // ---------------------------------------------------------------------
  // vsync synchroniser and falling-edge detector.
  // Two flops bring vsync into the clk domain, a third holds the previous
  // synchronised value, and the edge pulse itself is registered so that
  // frame_tick is a clean flop output three cycles after the vsync fall.
  // ---------------------------------------------------------------------
  logic vsync_s1;
  logic vsync_s2;
  logic vsync_d;
  logic frame_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_s1   <= 1'b1;
      vsync_s2   <= 1'b1;
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vsync_s1   <= bus.vsync;
      vsync_s2   <= vsync_s1;
      vsync_d    <= vsync_s2;
      frame_tick <= vsync_d & ~vsync_s2;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer state and counters
  // ---------------------------------------------------------------------
  logic [2:0] state_q,     state_d;
  logic [1:0] lives_q,     lives_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic [3:0] step_cnt_q,  step_cnt_d;
  logic       step_en_q,   step_en_d;
  logic       serve_q,     serve_d;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    serve_cnt_d = serve_cnt_q;
    step_cnt_d  = step_cnt_q;
    step_en_d   = 1'b0;
    serve_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_key) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        lives_d     = LIVES_INIT;
        serve_cnt_d = 8'd0;
        state_d     = ST_SERVE;
      end

      ST_SERVE: begin
        if (frame_tick) begin
          serve_cnt_d = serve_cnt_q + 8'd1;
          if (serve_cnt_d == SERVE_LAST) begin
            state_d    = ST_PLAY;
            serve_d    = 1'b1;
            step_cnt_d = 4'd0;
          end
        end
      end

      ST_PLAY: begin
        // Exits take priority over the step; a tick on an exit cycle is
        // dropped so the datapath never advances on the way out of PLAY.
        if (bus.bricks_empty) begin
          state_d = ST_WIN;
        end else if (bus.ball_lost) begin
          state_d = ST_LOST;
`ifdef GAME_PAUSE_EN
        end else if (bus.start_key) begin
          state_d = ST_PAUSE;
`endif
        end else if (frame_tick) begin
          if (step_cnt_q == STEP_LAST) begin
            step_en_d  = 1'b1;
            step_cnt_d = 4'd0;
          end else begin
            step_cnt_d = step_cnt_q + 4'd1;
          end
        end
      end

      ST_LOST: begin
        // lives is always >= 1 here; the guard keeps it from wrapping
        // should LIVES ever be misconfigured to 0.
        if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = ST_OVER;
        end else begin
          lives_d     = lives_q - 2'd1;
          serve_cnt_d = 8'd0;
          state_d     = ST_SERVE;
        end
      end

      ST_OVER, ST_WIN: begin
        if (bus.start_key) begin
          state_d = ST_LOAD;
        end
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        // Step count is held so stepping resumes in phase with the frame.
        if (bus.start_key) begin
          state_d = ST_PLAY;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lives_q     <= 2'd0;
      serve_cnt_q <= 8'd0;
      step_cnt_q  <= 4'd0;
      step_en_q   <= 1'b0;
      serve_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      serve_cnt_q <= serve_cnt_d;
      step_cnt_q  <= step_cnt_d;
      step_en_q   <= step_en_d;
      serve_q     <= serve_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: registered pulses, everything else decoded from state_q.
  // load_level is a state decode because LOAD lasts exactly one cycle.
  // ---------------------------------------------------------------------
  assign bus.step_en    = step_en_q;
  assign bus.serve      = serve_q;
  assign bus.load_level = (state_q == ST_LOAD);
  assign bus.lives      = lives_q;
  assign bus.state      = state_q;
  assign bus.game_over  = (state_q == ST_OVER);
  assign bus.win        = (state_q == ST_WIN);

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Self-checking bench for game_sequencer (SERVE_FRAMES=4, STEP_DIV=2).
//   A behavioural model of the game rules predicts every output on every
//   clock; directed scenarios add hand-computed expectations, and a final
//   phase drives random key / ball / brick events.
//   Honours GAME_PAUSE_EN the same way the design does.

`timescale 1ns/1ps

module tb_game_sequencer;

  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 4;
  localparam int STEP_DIV     = 2;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // spec state encodings
  localparam int IDLE = 0, LOAD = 1, SERVE = 2, PLAY = 3;
  localparam int LOST = 4, OVER = 5, WIN = 6, PAUSE = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_sequencer_if bus();

  game_sequencer #(
    .LIVES(LIVES),
    .SERVE_FRAMES(SERVE_FRAMES),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // vsync generator: 100-cycle frames, low for 8 cycles
  // ---------------------------------------------------------------------
  int phase    = 50;
  int fall_cyc = -1000;
  int falls    = 0;

  initial begin
    bus.vsync = 1'b1;
    forever begin
      @(negedge clk);
      if (phase == 0) begin
        bus.vsync = 1'b0;
        fall_cyc  = cyc;
        falls++;
      end else if (phase == 8) begin
        bus.vsync = 1'b1;
      end
      phase = (phase + 1) % 100;
    end
  end

  // ---------------------------------------------------------------------
  // Behavioural model. A sampled vsync fall becomes a frame event that the
  // game rules see three clocks later; pulses are visible the clock after.
  // ---------------------------------------------------------------------
  int m_state, m_lives, serve_ticks, play_ticks;
  bit m_step, m_serve, m_prev_v, tick;
  int tick_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_state     = IDLE;
        m_lives     = 0;
        serve_ticks = 0;
        play_ticks  = 0;
        m_step      = 0;
        m_serve     = 0;
        m_prev_v    = 1;
        tick_q.delete();
      end else begin
        tick = 0;
        while (tick_q.size() > 0 && tick_q[0] < cyc) void'(tick_q.pop_front());
        if (tick_q.size() > 0 && tick_q[0] == cyc) begin
          tick = 1;
          void'(tick_q.pop_front());
        end
        if (m_prev_v && !bus.vsync) tick_q.push_back(cyc + 3);
        m_prev_v = bus.vsync;
        m_step  = 0;
        m_serve = 0;
        case (m_state)
          IDLE: if (bus.start_key) m_state = LOAD;
          LOAD: begin
            m_lives     = LIVES;
            serve_ticks = 0;
            m_state     = SERVE;
          end
          SERVE: if (tick) begin
            serve_ticks++;
            if (serve_ticks == SERVE_FRAMES) begin
              m_serve    = 1;
              play_ticks = 0;
              m_state    = PLAY;
            end
          end
          PLAY: begin
            if (bus.bricks_empty)                m_state = WIN;
            else if (bus.ball_lost)              m_state = LOST;
            else if (PAUSE_EN && bus.start_key)  m_state = PAUSE;
            else if (tick) begin
              play_ticks++;
              if (play_ticks == STEP_DIV) begin
                m_step     = 1;
                play_ticks = 0;
              end
            end
          end
          LOST: begin
            m_state = (m_lives == 1) ? OVER : SERVE;
            m_lives = m_lives - 1;
            serve_ticks = 0;
          end
          OVER, WIN: if (bus.start_key) m_state = LOAD;
          PAUSE:     if (bus.start_key) m_state = PLAY;
          default:   m_state = IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-cycle compare against the model, plus pulse monitors
  // ---------------------------------------------------------------------
  logic [9:0] dut_vec, mdl_vec;
  int step_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      dut_vec = {bus.step_en, bus.load_level, bus.serve, bus.lives, bus.state,
                 bus.game_over, bus.win};
      mdl_vec = {m_step, (m_state == LOAD), m_serve, 2'(m_lives), 3'(m_state),
                 (m_state == OVER), (m_state == WIN)};
      check("outputs_vs_model", int'(dut_vec), int'(mdl_vec));
      if (bus.step_en) begin
        step_count++;
        check("step_latency", cyc - fall_cyc, 4);
      end
      if (bus.serve) check("serve_latency", cyc - fall_cyc, 4);
    end
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  task automatic pulse_start();
    bus.start_key = 1'b1;
    @(negedge clk);
    bus.start_key = 1'b0;
  endtask

  task automatic wait_state(input int s, input int limit);
    int n = 0;
    while (int'(bus.state) != s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", int'(bus.state), s);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != p && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, int'({bus.step_en, bus.load_level, bus.serve, bus.lives,
                      bus.state, bus.game_over, bus.win}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Directed scenarios followed by random play
  // ---------------------------------------------------------------------
  initial begin
    int falls0;
    int n;
    bus.start_key    = 1'b0;
    bus.ball_lost    = 1'b0;
    bus.bricks_empty = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("first_cycle_after_release");

    // start -> load -> serve on the 4th frame tick
    wait_phase(20);
    pulse_start();
    check("load_level_cycle1", int'(bus.load_level), 1);
    falls0 = falls;
    @(negedge clk);
    check("load_level_once", int'(bus.load_level), 0);
    check("lives_loaded", int'(bus.lives), 3);
    check("serve_state_cycle2", int'(bus.state), SERVE);
    n = 0;
    while (!bus.serve && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("serve_seen", int'(bus.serve), 1);
    check("serve_on_4th_tick", falls - falls0, 4);
    check("play_at_serve", int'(bus.state), PLAY);

    // 10 frames in PLAY with STEP_DIV=2 -> 5 steps
    step_count = 0;
    repeat (1002) @(negedge clk);
    check("steps_in_10_frames", step_count, 5);

    // three losses -> OVER
    for (int i = 0; i < 3; i++) begin
      wait_state(PLAY, 700);
      repeat ($urandom_range(1, 40)) @(negedge clk);
      bus.ball_lost = 1'b1;
      @(negedge clk);
      bus.ball_lost = 1'b0;
      check("lost_state", int'(bus.state), LOST);
      @(negedge clk);
      check("lives_after_loss", int'(bus.lives), 2 - i);
    end
    check("over_state", int'(bus.state), OVER);
    check("game_over_flag", int'(bus.game_over), 1);
    step_count = 0;
    repeat (300) @(negedge clk);
    check("no_step_in_over", step_count, 0);

    // pause / resume (or ignored key without the pause build)
    pulse_start();
    wait_state(PLAY, 700);
    repeat (2) @(negedge clk);
    pulse_start();
    check("pause_entry", int'(bus.state), PAUSE_EN ? PAUSE : PLAY);
    step_count = 0;
    repeat (500) @(negedge clk);
    check("steps_during_pause_window", int'(step_count != 0), int'(!PAUSE_EN));
    pulse_start();
    check("resume_state", int'(bus.state), PLAY);
    step_count = 0;
    repeat (300) @(negedge clk);
    check("steps_after_resume", int'(step_count != 0), 1);

    // bricks_empty and ball_lost together -> WIN, lives kept
    bus.bricks_empty = 1'b1;
    bus.ball_lost    = 1'b1;
    @(negedge clk);
    bus.bricks_empty = 1'b0;
    bus.ball_lost    = 1'b0;
    check("win_state", int'(bus.state), WIN);
    check("win_flag", int'(bus.win), 1);
    check("win_lives", int'(bus.lives), 3);

    // asynchronous reset in the middle of SERVE
    pulse_start();
    @(negedge clk);
    check("serve_before_reset", int'(bus.state), SERVE);
    wait_phase(40);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset_outputs");
    repeat (3) @(negedge clk);
    check_reset_outputs("held_reset_outputs");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_first_cycle");
    pulse_start();
    check("load_after_reset", int'(bus.load_level), 1);

    // random play, checked by the model every cycle
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      bus.start_key    = ($urandom_range(0, 149) == 0);
      bus.ball_lost    = (int'(bus.state) == PLAY) && ($urandom_range(0, 299) == 0);
      bus.bricks_empty = ($urandom_range(0, 799) == 0);
    end
    bus.start_key    = 1'b0;
    bus.ball_lost    = 1'b0;
    bus.bricks_empty = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
